shd_pair_feeder: RTL and testbench

Upstream companion of the window-sum aggregator in the stereo matching pipeline. Accepts one raster-ordered stream of per-pixel Hamming distances and emits, per accepted sample, a pair: the sample entering the aggregation window (lead) and the sample leaving it (trail). The trail sample is the same stream delayed by exactly WH image lines, WH*M samples. The block owns the WH-line circular buffer, the frame-fill bookkeeping and the valid alignment, so the aggregator only sees consistent lead/trail pairs.

---
 rtl/shd_pair_feeder_if.sv | 21 ++
 rtl/shd_pair_feeder.sv | 58 +++++
 tb/tb_shd_pair_feeder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/shd_pair_feeder_if.sv
// rtl/shd_pair_feeder_if.sv - sample stream in, lead/trail pair stream out
interface shd_pair_feeder_if #(
  parameter int NIBIT = 5
);
  logic [NIBIT-1:0] i_data;
  logic             i_dval;
  logic             i_sof;
  logic [NIBIT-1:0] o_data_l;
  logic [NIBIT-1:0] o_data_h;
  logic             o_dval;

  modport master (
    output i_data, i_dval, i_sof,
    input  o_data_l, o_data_h, o_dval
  );

  modport slave (
    input  i_data, i_dval, i_sof,
    output o_data_l, o_data_h, o_dval
  );
endinterface

// File: rtl/shd_pair_feeder.sv
// rtl/shd_pair_feeder.sv - WH-line circular delay emitting lead/trail sample pairs
module shd_pair_feeder #(
  parameter int WC = 7,
  parameter int WH = 13,
  parameter int M  = 650
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  shd_pair_feeder_if.slave    bus
);
  localparam int NIBIT = $clog2((WC ** 2) / 2);
  localparam int D     = WH * M;
  localparam int PW    = (D > 1) ? $clog2(D) : 1;
  localparam int CW    = $clog2(D + 1);

  logic [NIBIT-1:0] mem [D];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    addr;
  logic [PW-1:0]    ptr_nxt;
  logic [CW-1:0]    fill_cnt;
  logic [CW-1:0]    fill_base;
  logic [CW-1:0]    fill_nxt;
  logic [NIBIT-1:0] trail;

  // A frame start restarts at entry 0 with an empty fill, so stale entries stay hidden.
  always_comb begin
    addr      = bus.i_sof ? '0 : wr_ptr;
    fill_base = bus.i_sof ? '0 : fill_cnt;
    ptr_nxt   = (addr == PW'(D - 1)) ? '0 : addr + PW'(1);
    fill_nxt  = (fill_base == CW'(D)) ? fill_base : fill_base + CW'(1);
    trail     = (fill_base == CW'(D)) ? mem[addr] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      bus.o_data_l <= '0;
      bus.o_data_h <= '0;
      bus.o_dval   <= 1'b0;
    end else begin
      bus.o_dval <= bus.i_dval;
      if (bus.i_dval) begin
        wr_ptr       <= ptr_nxt;
        fill_cnt     <= fill_nxt;
        bus.o_data_l <= bus.i_data;
        bus.o_data_h <= trail;
      end
    end
  end

  // Buffer has no reset; the old entry is read above before this write lands.
  always_ff @(posedge i_clk) begin
    if (bus.i_dval) begin
      mem[addr] <= bus.i_data;
    end
  end
endmodule

// File: tb/tb_shd_pair_feeder.sv
// tb/tb_shd_pair_feeder.sv - randomized and directed checks against a frame-history model
module tb_shd_pair_feeder;
  localparam int WC = 7;
  localparam int WH = 3;
  localparam int M  = 4;
  localparam int D  = WH * M;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  shd_pair_feeder_if #(.NIBIT(NB)) bus ();

  shd_pair_feeder #(.WC(WC), .WH(WH), .M(M)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: all samples accepted in the current frame, in order.
  int hist[$];
  int exp_l = 0;
  int exp_h = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_l = 0;
    exp_h = 0;
  endtask

  task automatic step(input logic v, input logic s, input int d);
    int k;
    bus.i_dval = v;
    bus.i_sof  = s;
    bus.i_data = NB'(d);
    @(posedge clk);
    if (v) begin
      if (s) hist.delete();
      k = hist.size();
      exp_l = d;
      exp_h = (k >= D) ? hist[k - D] : 0;
      hist.push_back(d);
    end
    #1;
    chk("dval", int'(bus.o_dval), int'(v));
    chk("lead", int'(bus.o_data_l), exp_l);
    chk("trail", int'(bus.o_data_h), exp_h);
  endtask

  initial begin
    bus.i_dval = 1'b1;
    bus.i_sof  = 1'b0;
    bus.i_data = 5'd5;
    model_reset();

    // Reset held while stimulus is active
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dval", int'(bus.o_dval), 0);
    chk("rst_lead", int'(bus.o_data_l), 0);
    chk("rst_trail", int'(bus.o_data_h), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Fill: 1..30 with frame start on sample 1
    for (int k = 1; k <= 30; k++) step(1'b1, k == 1, k);
    chk("fill_last_trail", int'(bus.o_data_h), 18);

    // Same run with pseudo-random gaps; sof during gaps must be ignored
    for (int k = 1; k <= 30; ) begin
      if ($urandom_range(0, 99) < 40) begin
        step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      end else begin
        step(1'b1, k == 1, k);
        k++;
      end
    end
    chk("gap_last_trail", int'(bus.o_data_h), 18);

    // Wrap: 40 samples of k mod 32
    for (int k = 0; k < 40; k++) step(1'b1, k == 0, k % 32);

    // New frame mid-stream
    for (int k = 1; k <= 20; k++) step(1'b1, k == 1, k);
    step(1'b1, 1'b1, 9);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 20 + k % 8);
    chk("newframe_pair13_trail", int'(bus.o_data_h), 9);

    // Ignored sof while idle
    for (int k = 1; k <= 8; k++) step(1'b1, k == 1, k);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 31);
    for (int k = 9; k <= 20; k++) step(1'b1, 1'b0, k);
    chk("ignored_sof_trail", int'(bus.o_data_h), 8);

    // Random traffic with occasional frame starts
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 3),
           int'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-stream
    for (int k = 1; k <= 14; k++) step(1'b1, k == 1, k + 3);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_dval", int'(bus.o_dval), 0);
    chk("async_rst_lead", int'(bus.o_data_l), 0);
    chk("async_rst_trail", int'(bus.o_data_h), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // First accept after release, no sof, still sees an empty fill
    for (int k = 0; k < 26; k++) step(1'b1, 1'b0, int'($urandom_range(0, 31)));
    step(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
